// File: rtl/sqrt_display_checker_pkg.sv
// rtl/sqrt_display_checker_pkg.sv - shared widths, glyph codes and FSM states for the sqrt display checker
package sqrt_display_checker_pkg;

    localparam int DEF_X_W        = 7;
    localparam int DEF_ROOT_W     = 7;
    localparam int DEF_NUM_DIGITS = 6;

    // Active-low gfedcba segment patterns as driven onto the HEX displays
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DECODE,
        ST_SQUARE,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sqrt_display_checker_seg7_to_bcd.sv
// rtl/sqrt_display_checker_seg7_to_bcd.sv - combinational 7-segment glyph to BCD classifier
module seg7_to_bcd
    import sqrt_display_checker_pkg::*;
(
    input  logic [6:0] glyph_i,
    output logic       is_digit_o,
    output logic       is_blank_o,
    output logic [3:0] bcd_o
);

    always_comb begin
        is_digit_o = 1'b1;
        is_blank_o = 1'b0;
        bcd_o      = 4'd0;
        case (glyph_i)
            SEG_0:     bcd_o = 4'd0;
            SEG_1:     bcd_o = 4'd1;
            SEG_2:     bcd_o = 4'd2;
            SEG_3:     bcd_o = 4'd3;
            SEG_4:     bcd_o = 4'd4;
            SEG_5:     bcd_o = 4'd5;
            SEG_6:     bcd_o = 4'd6;
            SEG_7:     bcd_o = 4'd7;
            SEG_8:     bcd_o = 4'd8;
            SEG_9:     bcd_o = 4'd9;
            SEG_BLANK: begin
                is_digit_o = 1'b0;
                is_blank_o = 1'b1;
            end
            default:   is_digit_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/sqrt_display_checker.sv
// rtl/sqrt_display_checker.sv - decodes HEX5..HEX0 to a root and checks r*r <= x < (r+1)^2
module sqrt_display_checker
    import sqrt_display_checker_pkg::*;
#(
    parameter int X_W        = DEF_X_W,
    parameter int ROOT_W     = DEF_ROOT_W,
    parameter int NUM_DIGITS = DEF_NUM_DIGITS
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic                    start,
    input  logic [X_W-1:0]          x,
    input  logic [7*NUM_DIGITS-1:0] hex_in,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    bad_glyph,
    output logic                    overflow,
    output logic [ROOT_W-1:0]       root_val
);

    localparam int ACC_W   = ROOT_W + 4;
    localparam int MAC_W   = ACC_W + 4;
    localparam int SQ_W    = 2 * ROOT_W;
    localparam int HI_W    = SQ_W + 1;
    localparam int CNT_MAX = (NUM_DIGITS > ROOT_W) ? NUM_DIGITS : ROOT_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [ACC_W-1:0] ROOT_MAX = ACC_W'((1 << ROOT_W) - 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [X_W-1:0]            x_q, x_d;
    logic [7*NUM_DIGITS-1:0]   hex_q, hex_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic                      seen_q, seen_d;
    logic                      bad_q, bad_d;
    logic                      ovf_q, ovf_d;
    logic [SQ_W-1:0]           mcand_q, mcand_d;
    logic [ROOT_W-1:0]         mplier_q, mplier_d;
    logic [SQ_W-1:0]           sq_q, sq_d;
    logic                      pass_q, pass_d;
    logic [ROOT_W-1:0]         root_q, root_d;

    logic [6:0]                glyph;
    logic                      is_digit, is_blank;
    logic [3:0]                bcd;
    logic [MAC_W-1:0]          acc_mac;
    logic                      last_digit;
    logic [HI_W-1:0]           x_ext, sq_ext, hi;

    always_comb begin
        glyph = SEG_BLANK;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (CNT_W'(i) == cnt_q) glyph = hex_q[7*(NUM_DIGITS-1-i) +: 7];
        end
    end

    seg7_to_bcd u_seg7_to_bcd (
        .glyph_i    (glyph),
        .is_digit_o (is_digit),
        .is_blank_o (is_blank),
        .bcd_o      (bcd)
    );

    assign acc_mac    = MAC_W'(acc_q) * MAC_W'(10) + MAC_W'(bcd);
    assign last_digit = (cnt_q == CNT_W'(NUM_DIGITS - 1));
    assign x_ext      = HI_W'(x_q);
    assign sq_ext     = HI_W'(sq_q);
    assign hi         = sq_ext + (HI_W'(acc_q[ROOT_W-1:0]) << 1) + HI_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        hex_d    = hex_q;
        acc_d    = acc_q;
        seen_d   = seen_q;
        bad_d    = bad_q;
        ovf_d    = ovf_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sq_d     = sq_q;
        pass_d   = pass_q;
        root_d   = root_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                x_d     = x;
                hex_d   = hex_in;
                acc_d   = '0;
                seen_d  = 1'b0;
                bad_d   = 1'b0;
                ovf_d   = 1'b0;
                sq_d    = '0;
                pass_d  = 1'b0;
                root_d  = '0;
                cnt_d   = '0;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_digit) begin
                    acc_d  = (acc_mac > MAC_W'({ACC_W{1'b1}})) ? {ACC_W{1'b1}} : acc_mac[ACC_W-1:0];
                    seen_d = 1'b1;
                    if (acc_d > ROOT_MAX) ovf_d = 1'b1;
                end else if (!is_blank || seen_q || last_digit) begin
                    // Leading blanks are tolerated; anything else that is not a digit is an error
                    bad_d = 1'b1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    cnt_d    = '0;
                    mcand_d  = SQ_W'(acc_d[ROOT_W-1:0]);
                    mplier_d = acc_d[ROOT_W-1:0];
                    sq_d     = '0;
                    state_d  = ST_SQUARE;
                end
            end
            ST_SQUARE: begin
                if (mplier_q[0]) sq_d = sq_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ROOT_W - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                pass_d  = !bad_q && !ovf_q && (sq_ext <= x_ext) && (x_ext < hi);
                root_d  = ovf_q ? {ROOT_W{1'b1}} : acc_q[ROOT_W-1:0];
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // A start arriving with the done pulse chains straight into the next check
                state_d = start ? ST_CAPTURE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            hex_q    <= '0;
            acc_q    <= '0;
            seen_q   <= 1'b0;
            bad_q    <= 1'b0;
            ovf_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sq_q     <= '0;
            pass_q   <= 1'b0;
            root_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            hex_q    <= hex_d;
            acc_q    <= acc_d;
            seen_q   <= seen_d;
            bad_q    <= bad_d;
            ovf_q    <= ovf_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sq_q     <= sq_d;
            pass_q   <= pass_d;
            root_q   <= root_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign bad_glyph = bad_q;
    assign overflow  = ovf_q;
    assign root_val  = root_q;

endmodule

// File: tb/tb_sqrt_display_checker.sv
// tb/tb_sqrt_display_checker.sv - directed vector bench for sqrt_display_checker
module tb_sqrt_display_checker;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N;
    logic        start;
    logic [6:0]  x;
    logic [41:0] hex_in;
    logic        busy, done, pass, bad_glyph, overflow;
    logic [6:0]  root_val;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        string       name;
        logic [6:0]  xv;
        logic [41:0] hv;
        logic        p;
        logic        b;
        logic        o;
        logic [6:0]  r;
    } vec_t;

    vec_t vecs [12];

    always #5 CLOCK_50 = ~CLOCK_50;

    sqrt_display_checker dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .start     (start),
        .x         (x),
        .hex_in    (hex_in),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .bad_glyph (bad_glyph),
        .overflow  (overflow),
        .root_val  (root_val)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [41:0] num_hex(input int v);
        logic [41:0] h;
        int          t;
        h = {6{7'h7F}};
        t = v;
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || t != 0) begin
                h[i*7 +: 7] = seg_tbl[t % 10];
                t = t / 10;
            end
        end
        return h;
    endfunction

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Pulses start, scrambles inputs right after they were latched, waits for done
    task automatic run(input logic [6:0] xv, input logic [41:0] hv, output int lat);
        x      = xv;
        hex_in = hv;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        lat    = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                x      = ~xv;
                hex_in = {6{7'h06}};
            end
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat, r, ndone, first;

        RESET_N = 1'b0;
        start   = 1'b0;
        x       = '0;
        hex_in  = '1;
        tick();
        tick();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset pass", pass, 0);
        chk("reset bad_glyph", bad_glyph, 0);
        chk("reset overflow", overflow, 0);
        chk("reset root_val", root_val, 0);
        RESET_N = 1'b1;
        tick();

        vecs[0]  = '{"root11_x127", 7'd127, {{4{7'h7F}}, 7'h79, 7'h79}, 1'b1, 1'b0, 1'b0, 7'd11};
        vecs[1]  = '{"root6_x46",   7'd46,  {{5{7'h7F}}, 7'h02},        1'b1, 1'b0, 1'b0, 7'd6};
        vecs[2]  = '{"root7_x46",   7'd46,  {{5{7'h7F}}, 7'h78},        1'b0, 1'b0, 1'b0, 7'd7};
        vecs[3]  = '{"root0_x0",    7'd0,   {{5{7'h7F}}, 7'h40},        1'b1, 1'b0, 1'b0, 7'd0};
        vecs[4]  = '{"all_blank",   7'd0,   {6{7'h7F}},                 1'b0, 1'b1, 1'b0, 7'd0};
        vecs[5]  = '{"glyph_E",     7'd0,   {{5{7'h7F}}, 7'h06},        1'b0, 1'b1, 1'b0, 7'd0};
        vecs[6]  = '{"root200",     7'd127, {{3{7'h7F}}, 7'h24, 7'h40, 7'h40}, 1'b0, 1'b0, 1'b1, 7'd127};
        vecs[7]  = '{"inner_blank", 7'd127, {{3{7'h7F}}, 7'h79, 7'h7F, 7'h79}, 1'b0, 1'b1, 1'b0, 7'd11};
        vecs[8]  = '{"lead_zeros",  7'd121, {{4{7'h40}}, 7'h79, 7'h79}, 1'b1, 1'b0, 1'b0, 7'd11};
        vecs[9]  = '{"saturate",    7'd5,   {6{7'h10}},                 1'b0, 1'b0, 1'b1, 7'd127};
        vecs[10] = '{"root11_x120", 7'd120, {{4{7'h7F}}, 7'h79, 7'h79}, 1'b0, 1'b0, 1'b0, 7'd11};
        vecs[11] = '{"root10_x127", 7'd127, {{4{7'h7F}}, 7'h79, 7'h40}, 1'b0, 1'b0, 1'b0, 7'd10};

        foreach (vecs[i]) begin
            run(vecs[i].xv, vecs[i].hv, lat);
            chk({vecs[i].name, " latency"}, lat, 15);
            chk({vecs[i].name, " pass"}, pass, vecs[i].p);
            chk({vecs[i].name, " bad_glyph"}, bad_glyph, vecs[i].b);
            chk({vecs[i].name, " overflow"}, overflow, vecs[i].o);
            chk({vecs[i].name, " root_val"}, root_val, vecs[i].r);
            tick();
            chk({vecs[i].name, " done_one_cycle"}, done, 0);
            chk({vecs[i].name, " idle_after"}, busy, 0);
        end

        // start re-pulsed while busy is dropped, only one done
        x      = 7'd127;
        hex_in = num_hex(11);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        ndone  = 0;
        first  = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            start = (k == 3 || k == 10);
            if (done) begin
                ndone++;
                if (first < 0) first = k;
            end
        end
        start = 1'b0;
        chk("restart_ignored done_count", ndone, 1);
        chk("restart_ignored latency", first, 15);
        chk("restart_ignored pass", pass, 1);

        // reset in the middle of SQUARE aborts without a done pulse
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) tick();
        chk("midreset busy_before", busy, 1);
        RESET_N = 1'b0;
        tick();
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset pass", pass, 0);
        chk("midreset bad_glyph", bad_glyph, 0);
        chk("midreset overflow", overflow, 0);
        chk("midreset root_val", root_val, 0);
        RESET_N = 1'b1;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("midreset no_done", ndone, 0);

        // floor-sqrt sweep: correct root passes, root+1 fails
        r = 0;
        for (int xv = 0; xv < 128; xv++) begin
            while ((r + 1) * (r + 1) <= xv) r++;
            run(7'(xv), num_hex(r), lat);
            chk($sformatf("sweep x=%0d pass", xv), pass, 1);
            chk($sformatf("sweep x=%0d root", xv), root_val, r);
            tick();
            run(7'(xv), num_hex(r + 1), lat);
            chk($sformatf("sweep x=%0d root+1 pass", xv), pass, 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
